// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: opcodes, instruction fields, dispatch states.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SGT = 4'd2;

    // Instruction word layout: [15:12] codop, [11:8] rd, [7:4] rs1, [3:0] rs2
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RS1_LSB = 4;
    localparam int RS2_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2,
        ERR  = 2'd3
    } disp_state_t;

    // True for the opcodes the ALU actually implements
    function automatic logic op_supported(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SGT);
    endfunction

endpackage

// File: rtl/alu_dispatch_if.sv
// Bundle of instruction handshake, ALU bus, writeback and debug signals.
interface alu_dispatch_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  codop;
    logic [15:0] operando1;
    logic [15:0] operando2;
    logic [15:0] resultado;
    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic [15:0] wb_data;
    logic        err;
    logic        dbg_we;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_wdata;
    logic [15:0] dbg_rdata;

    // Environment side: fetch, ALU and debug host
    modport master (
        output instr, instr_valid, resultado, dbg_we, dbg_addr, dbg_wdata,
        input  instr_ready, codop, operando1, operando2, wb_valid, wb_reg, wb_data, err, dbg_rdata
    );

    // Dispatcher side
    modport slave (
        input  instr, instr_valid, resultado, dbg_we, dbg_addr, dbg_wdata,
        output instr_ready, codop, operando1, operando2, wb_valid, wb_reg, wb_data, err, dbg_rdata
    );
endinterface

// File: rtl/alu_regfile.sv
// 16x16 register file: one write port, three combinational read ports, R0 fixed at zero.
module alu_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [3:0]  raddr1,
    input  logic [3:0]  raddr2,
    input  logic [3:0]  raddr3,
    output logic [15:0] rdata1,
    output logic [15:0] rdata2,
    output logic [15:0] rdata3
);
    logic [15:0] mem_r [16];

    // Storage update; writes aimed at R0 are dropped so it never leaves zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                mem_r[i] <= 16'd0;
            end
        end else if (we && (waddr != 4'd0)) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 4'd0) ? 16'd0 : mem_r[raddr1];
    assign rdata2 = (raddr2 == 4'd0) ? 16'd0 : mem_r[raddr2];
    assign rdata3 = (raddr3 == 4'd0) ? 16'd0 : mem_r[raddr3];

endmodule

// File: rtl/alu_dispatch.sv
// Issue side of the ALU: accepts one instruction, drives operands, waits ALU_LAT
// cycles, captures the result and writes it back to the register file.
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    alu_dispatch_if.slave  bus
);
    localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

    disp_state_t state_r;
    disp_state_t state_nxt_s;
    logic [2:0]  cnt_r;
    logic [3:0]  rd_r;
    logic [3:0]  codop_r;
    logic [15:0] op1_r;
    logic [15:0] op2_r;
    logic        instr_ready_r;
    logic        wb_valid_r;
    logic [3:0]  wb_reg_r;
    logic [15:0] wb_data_r;
    logic        err_r;

    logic        xfer_s;
    logic        supp_s;
    logic        rf_we_s;
    logic [3:0]  rf_waddr_s;
    logic [15:0] rf_wdata_s;
    logic [15:0] rs1_data_s;
    logic [15:0] rs2_data_s;

    assign xfer_s = (state_r == IDLE) && bus.instr_valid;
    assign supp_s = op_supported(bus.instr[OP_LSB +: 4]);

    alu_regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (rf_we_s),
        .waddr  (rf_waddr_s),
        .wdata  (rf_wdata_s),
        .raddr1 (bus.instr[RS1_LSB +: 4]),
        .raddr2 (bus.instr[RS2_LSB +: 4]),
        .raddr3 (bus.dbg_addr),
        .rdata1 (rs1_data_s),
        .rdata2 (rs2_data_s),
        .rdata3 (bus.dbg_rdata)
    );

    // Register file write source: writeback in WB, debug port only while IDLE
    always_comb begin
        rf_we_s    = 1'b0;
        rf_waddr_s = 4'd0;
        rf_wdata_s = 16'd0;
        if (state_r == WB) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = wb_reg_r;
            rf_wdata_s = wb_data_r;
        end else begin
            rf_we_s    = bus.dbg_we && (state_r == IDLE);
            rf_waddr_s = bus.dbg_addr;
            rf_wdata_s = bus.dbg_wdata;
        end
    end

    // Next-state logic of the dispatch FSM
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.instr_valid) begin
                    state_nxt_s = supp_s ? EXEC : ERR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: begin
                if (cnt_r == 3'd1) begin
                    state_nxt_s = WB;
                end else begin
                    state_nxt_s = EXEC;
                end
            end
            WB:      state_nxt_s = IDLE;
            ERR:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register, latency counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= 3'd0;
            rd_r          <= 4'd0;
            codop_r       <= 4'd0;
            op1_r         <= 16'd0;
            op2_r         <= 16'd0;
            instr_ready_r <= 1'b1;
            wb_valid_r    <= 1'b0;
            wb_reg_r      <= 4'd0;
            wb_data_r     <= 16'd0;
            err_r         <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            instr_ready_r <= (state_nxt_s == IDLE);
            wb_valid_r    <= (state_nxt_s == WB);
            err_r         <= (state_nxt_s == ERR);
            if (xfer_s && supp_s) begin
                codop_r <= bus.instr[OP_LSB +: 4];
                op1_r   <= rs1_data_s;
                op2_r   <= rs2_data_s;
                rd_r    <= bus.instr[RD_LSB +: 4];
                cnt_r   <= LAT_INIT;
            end else if (state_r == EXEC) begin
                cnt_r <= cnt_r - 3'd1;
                if (cnt_r == 3'd1) begin
                    wb_data_r <= bus.resultado;
                    wb_reg_r  <= rd_r;
                end
            end
        end
    end

    assign bus.instr_ready = instr_ready_r;
    assign bus.codop       = codop_r;
    assign bus.operando1   = op1_r;
    assign bus.operando2   = op2_r;
    assign bus.wb_valid    = wb_valid_r;
    assign bus.wb_reg      = wb_reg_r;
    assign bus.wb_data     = wb_data_r;
    assign bus.err         = err_r;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch: two instances (ALU_LAT = 1 and 3), each fed by a
// behavioural ALU with matching latency; the same directed sequence runs on each in turn.
module tb_alu_dispatch;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [15:0] instr = 16'd0;
    logic        instr_valid = 1'b0;
    logic        dbg_we = 1'b0;
    logic [3:0]  dbg_addr = 4'd0;
    logic [15:0] dbg_wdata = 16'd0;
    int          lat = 1;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    alu_dispatch_if b1 ();
    alu_dispatch_if b3 ();

    alu_dispatch #(.ALU_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    alu_dispatch #(.ALU_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    // Stimulus reaches only the selected instance; the other stays idle
    assign b1.instr       = instr;
    assign b1.instr_valid = instr_valid && !sel;
    assign b1.dbg_we      = dbg_we && !sel;
    assign b1.dbg_addr    = dbg_addr;
    assign b1.dbg_wdata   = dbg_wdata;
    assign b3.instr       = instr;
    assign b3.instr_valid = instr_valid && sel;
    assign b3.dbg_we      = dbg_we && sel;
    assign b3.dbg_addr    = dbg_addr;
    assign b3.dbg_wdata   = dbg_wdata;

    function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SGT:  return (a > b) ? 16'd1 : 16'd0;
            default: return 16'hDEAD;
        endcase
    endfunction

    // ALU models: latency 1 is combinational, latency 3 has two register stages
    logic [15:0] p3a, p3b;
    assign b1.resultado = alu_f(b1.codop, b1.operando1, b1.operando2);
    always @(posedge clk) begin
        p3a <= alu_f(b3.codop, b3.operando1, b3.operando2);
        p3b <= p3a;
    end
    assign b3.resultado = p3b;

    wire [15:0] obs_ready = {15'd0, sel ? b3.instr_ready : b1.instr_ready};
    wire [15:0] obs_codop = {12'd0, sel ? b3.codop : b1.codop};
    wire [15:0] obs_op1   = sel ? b3.operando1 : b1.operando1;
    wire [15:0] obs_op2   = sel ? b3.operando2 : b1.operando2;
    wire [15:0] obs_wbv   = {15'd0, sel ? b3.wb_valid : b1.wb_valid};
    wire [15:0] obs_wbr   = {12'd0, sel ? b3.wb_reg : b1.wb_reg};
    wire [15:0] obs_wbd   = sel ? b3.wb_data : b1.wb_data;
    wire [15:0] obs_err   = {15'd0, sel ? b3.err : b1.err};
    wire [15:0] obs_dbg   = sel ? b3.dbg_rdata : b1.dbg_rdata;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (lat=%0d): got %h expected %h", tag, lat, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_write(input logic [3:0] a, input logic [15:0] d);
        dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
        tick();
        dbg_we = 1'b0;
    endtask

    task automatic dbg_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        check_val(tag, obs_dbg, exp);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (obs_ready !== 16'd1 && n < 30) begin
            tick();
            n++;
        end
        check_val("ready_wait", obs_ready, 16'd1);
    endtask

    // Issue one supported instruction and follow it to its writeback
    task automatic run_op(input logic [15:0] word, input logic [15:0] e1, input logic [15:0] e2,
                          input logic [15:0] ewb, input bit poke);
        logic [15:0] w;
        w = word;
        instr = word; instr_valid = 1'b1;
        wait_ready();
        tick();
        instr_valid = 1'b0;
        check_val("codop", obs_codop, {12'd0, w[15:12]});
        check_val("op1", obs_op1, e1);
        check_val("op2", obs_op2, e2);
        for (int i = 0; i < lat; i++) begin
            check_val("exec_no_wb", obs_wbv, 16'd0);
            check_val("exec_hold", obs_op1, e1);
            if (i == 0 && poke) begin
                dbg_we = 1'b1; dbg_addr = 4'd8; dbg_wdata = 16'hBEEF;
            end
            tick();
            dbg_we = 1'b0;
        end
        check_val("wb_valid", obs_wbv, 16'd1);
        check_val("wb_reg", obs_wbr, {12'd0, w[11:8]});
        check_val("wb_data", obs_wbd, ewb);
        tick();
        check_val("wb_pulse_end", obs_wbv, 16'd0);
        check_val("ready_after", obs_ready, 16'd1);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            int k;
            sel = s[0];
            lat = (s == 0) ? 1 : 3;
            rst = 1'b1; instr_valid = 1'b0; dbg_we = 1'b0;
            tick(); tick();
            rst = 1'b0;
            tick();

            // 1. reset clears registers and outputs
            dbg_write(4'd1, 16'd5);
            dbg_chk("dbg_r1", 4'd1, 16'd5);
            rst = 1'b1;
            dbg_chk("rst_r1", 4'd1, 16'd0);
            check_val("rst_ready", obs_ready, 16'd1);
            check_val("rst_wbv", obs_wbv, 16'd0);
            check_val("rst_err", obs_err, 16'd0);
            tick();
            rst = 1'b0;
            tick();

            // 2. ADD
            dbg_write(4'd1, 16'd5);
            dbg_write(4'd2, 16'd7);
            run_op(16'h0312, 16'd5, 16'd7, 16'd12, 1'b0);
            dbg_chk("add_r3", 4'd3, 16'd12);

            // 3. SUB wrap, SGT both ways
            dbg_write(4'd1, 16'd0);
            dbg_write(4'd2, 16'd1);
            run_op(16'h1412, 16'd0, 16'd1, 16'hFFFF, 1'b0);
            dbg_chk("sub_r4", 4'd4, 16'hFFFF);
            run_op(16'h2542, 16'hFFFF, 16'd1, 16'd1, 1'b0);
            dbg_chk("sgt_r5a", 4'd5, 16'd1);
            run_op(16'h2524, 16'd1, 16'hFFFF, 16'd0, 1'b0);
            dbg_chk("sgt_r5b", 4'd5, 16'd0);

            // 5. unsupported codop
            instr = 16'h9312; instr_valid = 1'b1;
            wait_ready();
            tick();
            instr_valid = 1'b0;
            check_val("err_pulse", obs_err, 16'd1);
            check_val("err_no_wb", obs_wbv, 16'd0);
            check_val("err_codop", obs_codop, 16'd2);
            check_val("err_op1", obs_op1, 16'd1);
            tick();
            check_val("err_end", obs_err, 16'd0);
            check_val("err_no_wb2", obs_wbv, 16'd0);
            check_val("err_ready", obs_ready, 16'd1);
            dbg_chk("err_r3", 4'd3, 16'd12);

            // 4. back-to-back with dependency
            dbg_write(4'd1, 16'd3);
            dbg_write(4'd2, 16'd4);
            instr = 16'h0612; instr_valid = 1'b1;
            wait_ready();
            tick();
            instr = 16'h0766;
            k = 0;
            while (obs_ready !== 16'd1 && k < 30) begin
                tick();
                k++;
            end
            tick();
            k++;
            instr_valid = 1'b0;
            check_val("b2b_gap", 16'(k), 16'(lat + 2));
            check_val("b2b_op1", obs_op1, 16'd7);
            for (int i = 0; i < lat; i++) tick();
            check_val("b2b_wbv", obs_wbv, 16'd1);
            check_val("b2b_wbr", obs_wbr, 16'd7);
            check_val("b2b_wbd", obs_wbd, 16'd14);
            tick();
            dbg_chk("b2b_r6", 4'd6, 16'd7);
            dbg_chk("b2b_r7", 4'd7, 16'd14);

            // 6a. writes to R0 are discarded
            run_op(16'h0012, 16'd3, 16'd4, 16'd7, 1'b0);
            dbg_chk("r0_wb", 4'd0, 16'd0);
            dbg_write(4'd0, 16'h1234);
            dbg_chk("r0_dbg", 4'd0, 16'd0);

            // 6c. debug write during EXEC is ignored
            run_op(16'h0312, 16'd3, 16'd4, 16'd7, 1'b1);
            dbg_chk("dbg_exec_r8", 4'd8, 16'd0);

            // 6b. reset mid-EXEC abandons the instruction
            instr = 16'h1312; instr_valid = 1'b1;
            wait_ready();
            tick();
            instr_valid = 1'b0;
            check_val("pre_rst_codop", obs_codop, 16'd1);
            rst = 1'b1;
            #1;
            check_val("mid_rst_codop", obs_codop, 16'd0);
            check_val("mid_rst_op1", obs_op1, 16'd0);
            check_val("mid_rst_ready", obs_ready, 16'd1);
            dbg_chk("mid_rst_r1", 4'd1, 16'd0);
            for (int i = 0; i < lat + 2; i++) begin
                tick();
                check_val("mid_rst_no_wb", obs_wbv, 16'd0);
                check_val("mid_rst_no_err", obs_err, 16'd0);
            end
            rst = 1'b0;
            tick();
            check_val("post_rst_no_wb", obs_wbv, 16'd0);
            dbg_chk("post_rst_r3", 4'd3, 16'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
